// File: rtl/bk_subtractor_pipe.sv
// bk_subtractor_pipe: two-stage Brent-Kung subtractor, diff = a - b - bin, with valid/ready handshake.
// Define BK_SUB_SAT_EN to saturate diff to the signed range on overflow (flags still report the raw result).
module bk_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG_W = $clog2(WIDTH);

    logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0] p0_q, p0_d, gu_q, gu_d, pu_q, pu_d;
    logic             c0_q, c0_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             adv1, adv2, accept, ld2, ovf_raw;
    logic [WIDTH-1:0] gu, pu, gd, raw;
    logic             s2_unused;

    always_comb begin
        adv2 = ~out_valid_q | out_ready;
        adv1 = ~s1_valid_q | adv2;
        accept = in_valid & adv1;
        // Up-sweep in place on (a, ~b) with the carry-in folded into bit 0 generate
        gu = a & ~b;
        pu = a ^ ~b;
        gu[0] = gu[0] | (pu[0] & ~bin);
        for (int l = 1; l <= LOG_W; l++) begin
            for (int i = (1 << l) - 1; i < WIDTH; i += (1 << l)) begin
                gu[i] = gu[i] | (pu[i] & gu[i - (1 << (l - 1))]);
                pu[i] = pu[i] & pu[i - (1 << (l - 1))];
            end
        end
        s1_valid_d = adv1 ? in_valid : s1_valid_q;
        p0_d = accept ? (a ^ ~b) : p0_q;
        gu_d = accept ? gu : gu_q;
        pu_d = accept ? pu : pu_q;
        c0_d = accept ? ~bin : c0_q;
        a_msb_d = accept ? a[WIDTH-1] : a_msb_q;
        b_msb_d = accept ? b[WIDTH-1] : b_msb_q;
        // Down-sweep fills in the remaining prefix carries
        gd = gu_q;
        for (int l = LOG_W - 1; l >= 1; l--) begin
            for (int i = (1 << l) + (1 << (l - 1)) - 1; i < WIDTH; i += (1 << l)) begin
                gd[i] = gd[i] | (pu_q[i] & gd[i - (1 << (l - 1))]);
            end
        end
        raw = p0_q ^ {gd[WIDTH-2:0], c0_q};
        ovf_raw = (a_msb_q ^ b_msb_q) & (raw[WIDTH-1] ^ a_msb_q);
        ld2 = adv2 & s1_valid_q;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        bout_d = ld2 ? ~gd[WIDTH-1] : bout_q;
        ovf_d = ld2 ? ovf_raw : ovf_q;
        zero_d = ld2 ? (raw == '0) : zero_q;
`ifdef BK_SUB_SAT_EN
        diff_d = ld2 ? (ovf_raw ? {a_msb_q, {(WIDTH-1){~a_msb_q}}} : raw) : diff_q;
`else
        diff_d = ld2 ? raw : diff_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            p0_q <= '0;
            gu_q <= '0;
            pu_q <= '0;
            c0_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            out_valid_q <= out_valid_d;
            p0_q <= p0_d;
            gu_q <= gu_d;
            pu_q <= pu_d;
            c0_q <= c0_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // Only the group-propagate bits the down-sweep needs are read back
    assign s2_unused = ^pu_q;
    assign in_ready = adv1;
    assign out_valid = out_valid_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf = ovf_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// tb_bk_subtractor_pipe: directed and random checks of bk_subtractor_pipe against an arithmetic model.
// Results are tracked in order with a queue of expected {bout, ovf, zero, diff}.
module tb_bk_subtractor_pipe;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic in_ready, out_valid, bout, ovf, zero;
    logic [31:0] a = '0, b = '0, diff;
    int n_chk = 0, n_pass = 0, n_out = 0, n0;
    logic [34:0] sb_q[$];

`ifdef BK_SUB_SAT_EN
    localparam logic [31:0] D3A = 32'h8000_0000, D3B = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] D3A = 32'h7FFF_FFFF, D3B = 32'h8000_0000;
`endif

    always #5 clk = ~clk;

    bk_subtractor_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] r;
        longint s;
        logic o;
        logic [31:0] d;
        r = {1'b0, x} - {1'b0, y} - {32'd0, c};
        s = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        d = r[31:0];
`ifdef BK_SUB_SAT_EN
        if (o) d = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {r[32], o, r[31:0] == 32'd0, d};
    endfunction

    task automatic step(input logic v, input logic [31:0] ai, input logic [31:0] bi, input logic ci, input logic r);
        logic [34:0] e;
        @(negedge clk);
        in_valid = v; a = ai; b = bi; bin = ci; out_ready = r;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            e = 'x;
            if (sb_q.size() > 0) e = sb_q.pop_front();
            chk("sb_result", {29'd0, bout, ovf, zero, diff}, {29'd0, e});
        end
        if (in_valid && in_ready) sb_q.push_back(model(a, b, bin));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {bout, ovf, zero, diff}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd5, 32'd3, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t1_lat1", out_valid, 0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t1_lat2", out_valid, 1);
        chk("t1_out", {bout, ovf, zero, diff}, {3'b000, 32'h2});
        step(1'b1, 32'd0, 32'd1, 1'b0, 1'b1);
        step(1'b1, 32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t2_neg", {out_valid, bout, ovf, zero, diff}, {4'b1100, 32'hFFFF_FFFF});
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t2_zero", {out_valid, bout, ovf, zero, diff}, {4'b1001, 32'h0});
        step(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t3_ovf_neg", {out_valid, bout, ovf, zero, diff}, {4'b1010, D3A});
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t3_ovf_pos", {out_valid, bout, ovf, zero, diff}, {4'b1110, D3B});
        drain("t3_drain");
        step(1'b1, 32'd100, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'd200, 32'd2, 1'b1, 1'b0);
        chk("t4_ready2", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'd300, 32'd3, 1'b0, 1'b0);
            chk("t4_stall_ready", in_ready, 0);
            chk("t4_hold", {out_valid, diff}, {1'b1, 32'd99});
        end
        n0 = n_out;
        step(1'b1, 32'd300, 32'd3, 1'b0, 1'b1);
        drain("t4_drain");
        chk("t4_count", 64'(n_out - n0), 64'd3);
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        drain("t5_drain");
        step(1'b1, 32'd7, 32'd2, 1'b0, 1'b0);
        step(1'b1, 32'd9, 32'd4, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("t6_full", {out_valid, in_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_outs", {bout, ovf, zero, diff}, 0);
        chk("t6_rst_ready", in_ready, 1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd50, 32'd8, 1'b1, 1'b1);
        chk("t6_ready", in_ready, 1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t6_lat1", out_valid, 0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t6_lat2", {out_valid, bout, ovf, zero, diff}, {4'b1000, 32'd41});
        drain("t6_drain");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
